// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - one-hot note encodings, song coordinate type and the practice song table
package note_pkg;

    localparam int w_note = 12;

    localparam logic [w_note-1:0] note_c  = 12'b1000_0000_0000;
    localparam logic [w_note-1:0] note_db = 12'b0100_0000_0000;
    localparam logic [w_note-1:0] note_d  = 12'b0010_0000_0000;
    localparam logic [w_note-1:0] note_eb = 12'b0001_0000_0000;
    localparam logic [w_note-1:0] note_e  = 12'b0000_1000_0000;
    localparam logic [w_note-1:0] note_f  = 12'b0000_0100_0000;
    localparam logic [w_note-1:0] note_gb = 12'b0000_0010_0000;
    localparam logic [w_note-1:0] note_g  = 12'b0000_0001_0000;
    localparam logic [w_note-1:0] note_ab = 12'b0000_0000_1000;
    localparam logic [w_note-1:0] note_a  = 12'b0000_0000_0100;
    localparam logic [w_note-1:0] note_bb = 12'b0000_0000_0010;
    localparam logic [w_note-1:0] note_b  = 12'b0000_0000_0001;
    localparam logic [w_note-1:0] no_note = 12'b0000_0000_0000;

    typedef struct packed {
        logic [9:0]        x;
        logic [8:0]        y;
        logic [w_note-1:0] note_name;
    } NoteCoord_t;

    localparam int NOTE_COUNT = 62;
    localparam int W_SONG_IDX = $clog2(NOTE_COUNT);

    // Semitone codes (C=0 .. B=11); element 0 is the first note of the song.
    localparam logic [0:NOTE_COUNT-1][3:0] SONG_TABLE = {
        4'd4, 4'd7, 4'd2, 4'd0, 4'd4, 4'd4, 4'd4, 4'd2, 4'd2, 4'd2,
        4'd4, 4'd7, 4'd7, 4'd4, 4'd2, 4'd0, 4'd2, 4'd4, 4'd4, 4'd4,
        4'd4, 4'd2, 4'd2, 4'd4, 4'd2, 4'd0, 4'd0, 4'd2, 4'd7, 4'd7,
        4'd9, 4'd7, 4'd5, 4'd4, 4'd2, 4'd0, 4'd2, 4'd4, 4'd5, 4'd7,
        4'd7, 4'd5, 4'd4, 4'd2, 4'd4, 4'd5, 4'd7, 4'd9, 4'd11, 4'd9,
        4'd7, 4'd4, 4'd2, 4'd0, 4'd2, 4'd4, 4'd4, 4'd2, 4'd2, 4'd4,
        4'd2, 4'd0
    };

    function automatic logic [w_note-1:0] code_to_note(input logic [3:0] code);
        return (code < 4'd12) ? (note_c >> code) : no_note;
    endfunction

    function automatic logic is_one_hot(input logic [w_note-1:0] n);
        return (n != no_note) && ((n & (n - 1'b1)) == no_note);
    endfunction

endpackage

// File: rtl/song_rom.sv
// rtl/song_rom.sv - combinational song index to note/screen-coordinate lookup
module song_rom
    import note_pkg::*;
(
    input  logic [W_SONG_IDX-1:0] idx,
    output NoteCoord_t            coord
);

    logic [3:0] code;

    always_comb begin
        code            = (int'(idx) < NOTE_COUNT) ? SONG_TABLE[idx] : 4'd0;
        coord.note_name = code_to_note(code);
        // Notes scroll left to right; higher pitches sit higher on screen.
        coord.x         = 10'd8 + 10'(idx) * 10'd10;
        coord.y         = 9'd400 - 9'(code) * 9'd24;
    end

endmodule

// File: rtl/song_follower.sv
// rtl/song_follower.sv - steps through the practice song and judges hits/misses per note
// Optional SONG_STRICT_MISS_EN: a wrong note held for HOLD_CYCLES counts as a miss.
module song_follower #(
    parameter int HOLD_CYCLES    = 2500000,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int NOTE_COUNT     = note_pkg::NOTE_COUNT,
    parameter int W_IDX          = $clog2(NOTE_COUNT),
    parameter int W_SCORE        = $clog2(NOTE_COUNT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [note_pkg::w_note-1:0] det_note,
    output logic [W_IDX-1:0]            note_idx,
    output logic [note_pkg::w_note-1:0] exp_note,
    output logic                        hit,
    output logic                        miss,
    output logic [W_SCORE-1:0]          hit_cnt,
    output logic [W_SCORE-1:0]          miss_cnt,
    output logic                        playing,
    output logic                        done
);
    import note_pkg::w_note;
    import note_pkg::W_SONG_IDX;
    import note_pkg::NoteCoord_t;
    import note_pkg::is_one_hot;

    localparam int W_HOLD = $clog2(HOLD_CYCLES + 1);
    localparam int W_TMR  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LISTEN, S_HOLD, S_RELEASE, S_DONE} state_t;

    state_t              state;
    logic [W_HOLD-1:0]   hold_cnt;
    logic [W_TMR-1:0]    timer;
    logic [w_note-1:0]   held_note;
    logic [w_note-1:0]   prev_note;

    logic [W_SONG_IDX-1:0] rom_idx;
    NoteCoord_t            rom_entry;
    logic [w_note-1:0]     rom_note;
    logic                  rom_unused;

    logic                det_cand;
    logic                same_note;
    logic [W_HOLD-1:0]   hold_nxt;
    logic                hold_done;
    logic                hold_hit;
    logic [W_TMR-1:0]    timer_nxt;
    logic                tmr_done;
    logic                last_note;

    assign rom_idx = W_SONG_IDX'(note_idx);

    song_rom u_song_rom (
        .idx   (rom_idx),
        .coord (rom_entry)
    );

    // Screen coordinates are for the graphics stage only.
    assign rom_unused = ^{rom_entry.x, rom_entry.y};
    assign rom_note   = rom_entry.note_name;
    assign exp_note   = playing ? rom_note : '0;

`ifdef SONG_STRICT_MISS_EN
    assign det_cand = is_one_hot(det_note);
`else
    assign det_cand = is_one_hot(det_note) && (det_note == rom_note);
`endif

    assign same_note = (state == S_HOLD) && (det_note == held_note);
    assign hold_nxt  = same_note ? hold_cnt + 1'b1 : W_HOLD'(1);
    assign hold_done = det_cand && (hold_nxt == W_HOLD'(HOLD_CYCLES));
    assign hold_hit  = hold_done && (det_note == rom_note);
    assign timer_nxt = timer + 1'b1;
    assign tmr_done  = (timer_nxt == W_TMR'(TIMEOUT_CYCLES));
    assign last_note = (note_idx == W_IDX'(NOTE_COUNT - 1));

    function automatic logic [W_SCORE-1:0] sat_inc(input logic [W_SCORE-1:0] v);
        return (v == W_SCORE'(NOTE_COUNT)) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            note_idx  <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            playing   <= 1'b0;
            done      <= 1'b0;
            hold_cnt  <= '0;
            timer     <= '0;
            held_note <= '0;
            prev_note <= '0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            if (start) begin
                state     <= S_LISTEN;
                note_idx  <= '0;
                hit_cnt   <= '0;
                miss_cnt  <= '0;
                playing   <= 1'b1;
                done      <= 1'b0;
                hold_cnt  <= '0;
                timer     <= '0;
                held_note <= '0;
                prev_note <= '0;
            end else begin
                case (state)
                    S_LISTEN, S_HOLD: begin
                        timer <= timer_nxt;
                        if (hold_hit) begin
                            // A hit beats a timeout landing on the same cycle.
                            hit       <= 1'b1;
                            hit_cnt   <= sat_inc(hit_cnt);
                            prev_note <= rom_note;
                            hold_cnt  <= '0;
                            timer     <= '0;
                            if (last_note) begin
                                state   <= S_DONE;
                                playing <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                note_idx <= note_idx + 1'b1;
                                state    <= S_RELEASE;
                            end
                        end else if (hold_done || tmr_done) begin
                            miss     <= 1'b1;
                            miss_cnt <= sat_inc(miss_cnt);
                            hold_cnt <= '0;
                            timer    <= '0;
                            if (last_note) begin
                                state   <= S_DONE;
                                playing <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                note_idx <= note_idx + 1'b1;
                                state    <= S_LISTEN;
                            end
                        end else if (det_cand) begin
                            state     <= S_HOLD;
                            hold_cnt  <= hold_nxt;
                            held_note <= det_note;
                        end else begin
                            state    <= S_LISTEN;
                            hold_cnt <= '0;
                        end
                    end
                    S_RELEASE: begin
                        // Repeated notes must be re-struck, not just held over.
                        if (det_note != prev_note) begin
                            state <= S_LISTEN;
                            timer <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/song_follower.md
Name: song_follower

Overview:
- Downstream consumer of the thresholded note detector output (12-bit one-hot `t_note`, zero = no note).
- Steps through the fixed practice song, one note at a time.
- Judges each note: a hit needs the expected note held stably for `HOLD_CYCLES`; a miss is declared after `TIMEOUT_CYCLES`.
- Exposes progress, score and the expected note to the seven-segment and graphics stages.

Parameters:
- `HOLD_CYCLES`, 2500000: consecutive cycles the matching note must be present to count a hit (50 ms at 50 MHz).
- `TIMEOUT_CYCLES`, 100000000: cycles allowed per note before a miss (2 s at 50 MHz).
- `NOTE_COUNT`, 62: song length; must match the song table length.
- `W_IDX`, $clog2(NOTE_COUNT): index width.
- `W_SCORE`, $clog2(NOTE_COUNT+1): hit/miss counter width.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle pulse; starts or restarts the song.
- `det_note` input 12: thresholded detected note, one-hot or zero.
- `note_idx` output W_IDX: index of the current song note.
- `exp_note` output 12: expected note (one-hot); zero when not playing.
- `hit` output 1: one-cycle pulse on a hit.
- `miss` output 1: one-cycle pulse on a miss.
- `hit_cnt` output W_SCORE: hits this run.
- `miss_cnt` output W_SCORE: misses this run.
- `playing` output 1: FSM is in LISTEN, HOLD or RELEASE.
- `done` output 1: song finished.

Behaviour:
- Reset (asynchronous, any state):
  - State IDLE.
  - `note_idx`=0, `hit_cnt`=0, `miss_cnt`=0, `hit`=0, `miss`=0, `playing`=0, `done`=0.
  - Hold and timeout counters = 0.
- `exp_note` is a combinational song-table lookup at `note_idx` when `playing`=1, else 0.
- All other outputs are registered.
- States:
  - IDLE: on `start` → LISTEN; `idx`=0, counters cleared, timer cleared.
  - LISTEN:
    - `det_note`==`exp_note` (nonzero) → HOLD, hold counter = 1.
    - Timer increments every cycle in LISTEN and HOLD.
  - HOLD:
    - While matching, hold counter increments.
    - Hold counter reaching `HOLD_CYCLES` → hit.
    - Mismatch → LISTEN, hold counter = 0, timer keeps running.
  - Hit:
    - `hit` pulses for 1 cycle; `hit_cnt`++.
    - Last note → DONE; otherwise `idx`++ and → RELEASE.
  - Timer reaching `TIMEOUT_CYCLES` in LISTEN or HOLD → miss:
    - `miss` pulses for 1 cycle; `miss_cnt`++.
    - Last note → DONE; otherwise `idx`++, → LISTEN, timer cleared.
    - No release is needed after a miss.
  - RELEASE:
    - Waits for `det_note` != previous expected note (silence or a different note), then → LISTEN with timer cleared.
    - The comparison uses a registered copy of the previous expected note.
    - This prevents repeated notes (e.g. G,G) from being counted twice.
    - Timer is frozen in RELEASE.
  - DONE: `done`=1, `playing`=0, `note_idx` holds `NOTE_COUNT-1`; `start` → restart as from IDLE.
- Boundary rules:
  - Hit and timeout in the same cycle: hit wins, no miss.
  - `start` in any state except reset restarts from index 0 and clears the counters, next cycle.
  - `start` coincident with a hit or miss: restart wins, no pulse.
  - Non-one-hot `det_note` never matches.
  - Counters saturate; they cannot exceed `NOTE_COUNT` by construction.
  - `hit` and `miss` are never both 1 in the same cycle.
- Latency: `hit` asserts on the cycle after the `HOLD_CYCLES`-th consecutive matching cycle.

Optional Feature:
- Macro: `SONG_STRICT_MISS_EN`.
- Defined: a wrong nonzero note held stably for `HOLD_CYCLES` in LISTEN counts as an immediate miss (same advance rules as a timeout), using the hold counter on the wrong note.
- Undefined: wrong notes are ignored; only the timeout produces misses.

Decomposition:
- Package `note_pkg`:
  - `w_note`=12.
  - One-hot note constants C..B, flats and `no_note`.
  - `NoteCoord_t` struct (x, y, `note_name`).
  - `NOTE_COUNT` and the song table constant.
- Sub-module `song_rom`: combinational index → `NoteCoord_t` lookup. `song_follower` uses its `note_name`; graphics reuses the x/y fields.

Test Plan:
1. Reset mid-HOLD: assert `rst` → next cycle all outputs 0, `exp_note`=0; `start` → `exp_note`=E (12'b0000_1000_0000).
2. `HOLD_CYCLES`=4, `TIMEOUT_CYCLES`=20: `start`, drive E for 4 cycles → `hit` one pulse, `hit_cnt`=1, `note_idx`=1, `exp_note`=G after release; drive 0 → LISTEN.
3. Drive E, then G for 3 cycles, 0 for 1, G for 4 → exactly one hit at the 4th consecutive G; 3 cycles alone give no hit.
4. Drive nothing for 20 cycles → `miss` pulse, `miss_cnt`=1, `note_idx` advances, timer restarts; drive a wrong note D for 10 cycles without the macro → no miss until 20.
5. Repeated note (song indices 28/29 G,G): hold G continuously → only one hit until `det_note` drops to 0 for ≥1 cycle.
6. `NOTE_COUNT`=4: play E,G,D,C → 4 hits, `done`=1, `playing`=0; `start` → `hit_cnt`=0, `note_idx`=0. With `SONG_STRICT_MISS_EN`: hold D on expected E for 4 cycles → `miss`.
